// File: rtl/ahfp_pkg.sv
// Shared constants and state encoding for the ahfp_* floating-point custom instructions.
package ahfp_pkg;

    localparam int FP_EXP_W     = 8;
    localparam int FP_MAN_W     = 23;
    localparam int FP_ALIGN_CAP = 27;
    localparam int FP_BIAS      = 127;
    localparam int FP_EXP_MAX   = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] MAXF = 32'h7F7F_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        PACK,
        DONE
    } state_e;

endpackage

// File: rtl/ahfp_add_sub_mc_unpack.sv
// Combinational operand classifier: zero (denormals flushed), inf, NaN, plus
// sign, biased exponent and significand with the hidden bit restored.
module ahfp_add_sub_mc_unpack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op_i,
    output logic                 sign_o,
    output logic [EXP_W-1:0]     exp_o,
    output logic [MAN_W:0]       sig_o,
    output logic                 zero_o,
    output logic                 inf_o,
    output logic                 nan_o
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_ones;

    assign exp_f    = op_i[EXP_W+MAN_W-1:MAN_W];
    assign man_f    = op_i[MAN_W-1:0];
    assign exp_ones = &exp_f;

    assign sign_o = op_i[EXP_W+MAN_W];
    assign exp_o  = exp_f;
    assign zero_o = (exp_f == '0);
    assign inf_o  = exp_ones && (man_f == '0);
    assign nan_o  = exp_ones && (man_f != '0);
    assign sig_o  = zero_o ? '0 : {1'b1, man_f};

endmodule

// File: rtl/ahfp_add_sub_mc.sv
// Multi-cycle IEEE single add/sub custom instruction (start/done handshake).
// Alignment and normalisation move one bit per enabled cycle; rounding is toward zero.
module ahfp_add_sub_mc
    import ahfp_pkg::*;
#(
    parameter int EXP_W     = FP_EXP_W,
    parameter int MAN_W     = FP_MAN_W,
    parameter int ALIGN_CAP = FP_ALIGN_CAP
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clk_en,
    input  logic                 start,
    input  logic                 n,
    input  logic [EXP_W+MAN_W:0] dataa,
    input  logic [EXP_W+MAN_W:0] datab,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 done
);

    localparam int FP_W  = 1 + EXP_W + MAN_W;
    localparam int EXT_W = MAN_W + 4;             // hidden + mantissa + G/R/S
    localparam int XE_W  = EXP_W + 1;
    localparam int CNT_W = $clog2(ALIGN_CAP + 1);

    localparam logic [FP_W-1:0] QNAN_V = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [FP_W-2:0] MAXF_V = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    localparam logic [XE_W-1:0] EMAX_V = {1'b0, {EXP_W{1'b1}}};

    state_e             state_q, state_d;
    logic [FP_W-1:0]    opa_q, opa_d, opb_q, opb_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [XE_W-1:0]    ea_q, ea_d;
    logic [EXT_W:0]     ma_q, ma_d;
    logic [EXT_W-1:0]   mb_q, mb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               spec_q, spec_d, zero_q, zero_d;
    logic [FP_W-1:0]    spec_val_q, spec_val_d;
    logic [FP_W-1:0]    result_q, result_d;
    logic               done_q, done_d;

    logic               a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W:0]     a_sig, b_sig;

    ahfp_add_sub_mc_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unp_a (
        .op_i(opa_q), .sign_o(a_sign), .exp_o(a_exp), .sig_o(a_sig),
        .zero_o(a_zero), .inf_o(a_inf), .nan_o(a_nan)
    );

    ahfp_add_sub_mc_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unp_b (
        .op_i(opb_q), .sign_o(b_sign), .exp_o(b_exp), .sig_o(b_sig),
        .zero_o(b_zero), .inf_o(b_inf), .nan_o(b_nan)
    );

    // Larger magnitude becomes A so the magnitude difference is never negative.
    logic               swap, special;
    logic               big_sign, small_sign;
    logic [EXP_W-1:0]   big_exp, small_exp, diff;
    logic [MAN_W:0]     big_sig, small_sig;
    logic [CNT_W-1:0]   shamt;
    logic [FP_W-1:0]    spec_val;

    assign swap       = opb_q[FP_W-2:0] > opa_q[FP_W-2:0];
    assign big_sign   = swap ? b_sign : a_sign;
    assign small_sign = swap ? a_sign : b_sign;
    assign big_exp    = swap ? b_exp  : a_exp;
    assign small_exp  = swap ? a_exp  : b_exp;
    assign big_sig    = swap ? b_sig  : a_sig;
    assign small_sig  = swap ? a_sig  : b_sig;
    assign diff       = big_exp - small_exp;
    assign shamt      = (diff > EXP_W'(ALIGN_CAP)) ? CNT_W'(ALIGN_CAP) : CNT_W'(diff);
    assign special    = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    always_comb begin
        spec_val = opa_q;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign)))
            spec_val = QNAN_V;
        else if (a_inf)
            spec_val = {a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (b_inf)
            spec_val = {b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (a_zero && b_zero)
            spec_val = {a_sign & b_sign, {(FP_W-1){1'b0}}};
        else if (a_zero)
            spec_val = opb_q;
    end

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        ea_d       = ea_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        zero_d     = zero_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = dataa;
                    opb_d   = {datab[FP_W-1] ^ n, datab[FP_W-2:0]};
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                spec_d     = special;
                spec_val_d = spec_val;
                zero_d     = 1'b0;
                sa_d       = big_sign;
                sb_d       = small_sign;
                ea_d       = {1'b0, big_exp};
                ma_d       = {1'b0, big_sig, 3'b000};
                mb_d       = {small_sig, 3'b000};
                cnt_d      = shamt;
                if (special)            state_d = PACK;
                else if (shamt == '0)   state_d = ADD;
                else                    state_d = ALIGN;
            end
            ALIGN: begin
                mb_d  = {1'b0, mb_q[EXT_W-1:2], |mb_q[1:0]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ADD;
            end
            ADD: begin
                ma_d    = (sa_q == sb_q) ? ma_q + {1'b0, mb_q} : ma_q - {1'b0, mb_q};
                state_d = NORM;
            end
            NORM: begin
                if (ma_q[EXT_W]) begin
                    ma_d    = {1'b0, ma_q[EXT_W:2], |ma_q[1:0]};
                    ea_d    = ea_q + XE_W'(1);
                    state_d = PACK;
                end else if (ma_q == '0) begin
                    // Exact cancellation of two non-zero values is always +0.
                    zero_d  = 1'b1;
                    sa_d    = 1'b0;
                    state_d = PACK;
                end else if (ma_q[EXT_W-1]) begin
                    state_d = PACK;
                end else if (ea_q == XE_W'(1)) begin
                    zero_d  = 1'b1;
                    state_d = PACK;
                end else begin
                    ma_d = {ma_q[EXT_W-1:0], 1'b0};
                    ea_d = ea_q - XE_W'(1);
                end
            end
            PACK: begin
                if (spec_q)
                    result_d = spec_val_q;
                else if (zero_q)
                    result_d = {sa_q, {(FP_W-1){1'b0}}};
                else if (ea_q >= EMAX_V)
                    result_d = {sa_q, MAXF_V};
                else
                    result_d = {sa_q, ea_q[EXP_W-1:0], ma_q[EXT_W-2:3]};
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            ea_q       <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            zero_q     <= 1'b0;
            spec_val_q <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            ea_q       <= ea_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            zero_q     <= zero_d;
            spec_val_q <= spec_val_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule
